io_bus_timer_responder: RTL and testbench

IO_BUS_TIMER_RESPONDER -- requirements
Module: io_bus_timer_responder

---
 rtl/io_bus_timer_responder.sv | 241 ++++++++++++++++++++++++
 tb/tb_io_bus_timer_responder.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/io_bus_timer_responder.sv
// Bus-attached down-counting timer with ID/scratch registers and a 4-state handshake.
// Optional prescaler enabled by defining IO_BUS_TIMER_PRESCALE_EN.
module io_bus_timer_responder #(
   parameter int unsigned WAIT_STATES = 1,
   parameter logic [15:0] ID_VALUE    = 16'h5A17
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] io_address,
   input  logic        io_bus_enable,
   input  logic [1:0]  io_byte_enable,
   input  logic        io_rw,
   input  logic [15:0] io_write_data,
   output logic [15:0] io_read_data,
   output logic        io_acknowledge,
   output logic        io_irq
);

   localparam logic [15:0] ADDR_ID       = 16'h0000;
   localparam logic [15:0] ADDR_SCRATCH  = 16'h0002;
   localparam logic [15:0] ADDR_LOAD     = 16'h0004;
   localparam logic [15:0] ADDR_CTRL     = 16'h0006;
   localparam logic [15:0] ADDR_COUNT    = 16'h0008;
   localparam logic [15:0] ADDR_STATUS   = 16'h000A;
`ifdef IO_BUS_TIMER_PRESCALE_EN
   localparam logic [15:0] ADDR_PRESCALE = 16'h000C;
`endif

   localparam int unsigned CTRL_ENABLE     = 0;
   localparam int unsigned CTRL_AUTORELOAD = 1;
   localparam int unsigned CTRL_IRQ_EN     = 2;

   typedef enum logic [1:0] {StIdle, StWait, StAck, StHold} state_e;

   state_e      state_q, state_d;
   logic [3:0]  wait_cnt_q, wait_cnt_d;

   logic [14:0] addr_q;
   logic        rw_q;
   logic [15:0] wdata_q;
   logic [1:0]  be_q;

   logic [15:0] scratch_q, scratch_d;
   logic [15:0] load_q, load_d;
   logic [2:0]  ctrl_q, ctrl_d;
   logic [15:0] count_q, count_d;
   logic        expired_q, expired_d;
   logic        irq_q;

`ifdef IO_BUS_TIMER_PRESCALE_EN
   logic [7:0]  prescale_q, prescale_d;
   logic [7:0]  ps_cnt_q, ps_cnt_d;
`endif

   logic        capture;
   logic        wr_en;
   logic        tick;
   logic        expire;
   logic        status_clr;
   logic [15:0] word_addr;
   logic        unused_addr_lsb;

   // Byte addressing: the lane select is carried by io_byte_enable, not address bit 0.
   assign unused_addr_lsb = io_address[0];
   assign word_addr       = {addr_q, 1'b0};
   assign capture         = (state_q == StIdle) && io_bus_enable;
   assign wr_en           = (state_q == StAck) && !rw_q;

   function automatic logic [15:0] merge_lanes(input logic [15:0] old_val,
                                               input logic [15:0] new_val,
                                               input logic [1:0]  lanes);
      logic [15:0] res;
      res = old_val;
      if (lanes[0]) res[7:0]  = new_val[7:0];
      if (lanes[1]) res[15:8] = new_val[15:8];
      return res;
   endfunction

   // Bus handshake.
   always_comb begin
      state_d    = state_q;
      wait_cnt_d = wait_cnt_q;
      unique case (state_q)
         StIdle: begin
            if (io_bus_enable) begin
               wait_cnt_d = '0;
               state_d    = (WAIT_STATES == 0) ? StAck : StWait;
            end
         end
         StWait: begin
            if (wait_cnt_q == 4'(WAIT_STATES - 1)) begin
               state_d = StAck;
            end else begin
               wait_cnt_d = wait_cnt_q + 4'd1;
            end
         end
         StAck: begin
            state_d = StHold;
         end
         StHold: begin
            if (!io_bus_enable) state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Timer and register write path.
   always_comb begin
      scratch_d  = scratch_q;
      load_d     = load_q;
      ctrl_d     = ctrl_q;
      count_d    = count_q;
      expire     = 1'b0;
      status_clr = 1'b0;
`ifdef IO_BUS_TIMER_PRESCALE_EN
      prescale_d = prescale_q;
      ps_cnt_d   = ps_cnt_q;
      tick       = 1'b0;
      if (ctrl_q[CTRL_ENABLE]) begin
         if (ps_cnt_q == prescale_q) begin
            tick     = 1'b1;
            ps_cnt_d = '0;
         end else begin
            ps_cnt_d = ps_cnt_q + 8'd1;
         end
      end
`else
      tick       = ctrl_q[CTRL_ENABLE];
`endif

      if (tick) begin
         if (count_q == 16'h0000) begin
            expire = 1'b1;
            if (ctrl_q[CTRL_AUTORELOAD]) begin
               count_d = load_q;
            end else begin
               ctrl_d[CTRL_ENABLE] = 1'b0;
            end
         end else begin
            count_d = count_q - 16'd1;
         end
      end

      // A bus write to CTRL overrides whatever the timer did to CTRL this cycle.
      if (wr_en) begin
         case (word_addr)
            ADDR_SCRATCH: scratch_d = merge_lanes(scratch_q, wdata_q, be_q);
            ADDR_LOAD:    load_d    = merge_lanes(load_q, wdata_q, be_q);
            ADDR_CTRL: begin
               if (be_q[0]) begin
                  ctrl_d = wdata_q[2:0];
                  if (wdata_q[CTRL_ENABLE] && !ctrl_q[CTRL_ENABLE]) begin
                     count_d  = load_q;
`ifdef IO_BUS_TIMER_PRESCALE_EN
                     ps_cnt_d = '0;
`endif
                  end
               end
            end
            ADDR_STATUS: begin
               if (be_q[0] && wdata_q[0]) status_clr = 1'b1;
            end
`ifdef IO_BUS_TIMER_PRESCALE_EN
            ADDR_PRESCALE: begin
               if (be_q[0]) prescale_d = wdata_q[7:0];
            end
`endif
            default: begin
            end
         endcase
      end

      // Expiry beats a simultaneous write-1-to-clear.
      expired_d = expire | (expired_q & ~status_clr);
   end

   // Read mux; data only leaves the block during the acknowledge cycle.
   always_comb begin
      io_read_data = 16'h0000;
      if ((state_q == StAck) && rw_q) begin
         case (word_addr)
            ADDR_ID:       io_read_data = ID_VALUE;
            ADDR_SCRATCH:  io_read_data = scratch_q;
            ADDR_LOAD:     io_read_data = load_q;
            ADDR_CTRL:     io_read_data = {13'h0000, ctrl_q};
            ADDR_COUNT:    io_read_data = count_q;
            ADDR_STATUS:   io_read_data = {15'h0000, expired_q};
`ifdef IO_BUS_TIMER_PRESCALE_EN
            ADDR_PRESCALE: io_read_data = {8'h00, prescale_q};
`endif
            default:       io_read_data = 16'h0000;
         endcase
      end
   end

   assign io_acknowledge = (state_q == StAck);
   assign io_irq         = irq_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= StIdle;
         wait_cnt_q <= '0;
         addr_q     <= '0;
         rw_q       <= 1'b0;
         wdata_q    <= '0;
         be_q       <= '0;
         scratch_q  <= '0;
         load_q     <= '0;
         ctrl_q     <= '0;
         count_q    <= '0;
         expired_q  <= 1'b0;
         irq_q      <= 1'b0;
`ifdef IO_BUS_TIMER_PRESCALE_EN
         prescale_q <= '0;
         ps_cnt_q   <= '0;
`endif
      end else begin
         state_q    <= state_d;
         wait_cnt_q <= wait_cnt_d;
         if (capture) begin
            addr_q  <= io_address[15:1];
            rw_q    <= io_rw;
            wdata_q <= io_write_data;
            be_q    <= io_byte_enable;
         end
         scratch_q  <= scratch_d;
         load_q     <= load_d;
         ctrl_q     <= ctrl_d;
         count_q    <= count_d;
         expired_q  <= expired_d;
         irq_q      <= expired_q & ctrl_q[CTRL_IRQ_EN];
`ifdef IO_BUS_TIMER_PRESCALE_EN
         prescale_q <= prescale_d;
         ps_cnt_q   <= ps_cnt_d;
`endif
      end
   end

endmodule

// File: tb/tb_io_bus_timer_responder.sv
// Directed bench for io_bus_timer_responder (default WAIT_STATES=1).
// Covers handshake latency, byte lanes, timer expiry/reload, W1C races and reset.
module tb_io_bus_timer_responder;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] io_address;
   logic        io_bus_enable;
   logic [1:0]  io_byte_enable;
   logic        io_rw;
   logic [15:0] io_write_data;
   logic [15:0] io_read_data;
   logic        io_acknowledge;
   logic        io_irq;

   int total  = 0;
   int passed = 0;

   io_bus_timer_responder dut (
      .clk            (clk),
      .reset          (reset),
      .io_address     (io_address),
      .io_bus_enable  (io_bus_enable),
      .io_byte_enable (io_byte_enable),
      .io_rw          (io_rw),
      .io_write_data  (io_write_data),
      .io_read_data   (io_read_data),
      .io_acknowledge (io_acknowledge),
      .io_irq         (io_irq)
   );

   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
   endtask

   // One bus transfer. With hold=0 it returns #1 after the edge that commits a write.
   task automatic xfer(input logic rw, input logic [15:0] addr, input logic [15:0] wdata,
                       input logic [1:0] be, input int hold,
                       output logic [15:0] rdata, output int lat, output int extra);
      int n;
      bit got;
      @(posedge clk);
      @(negedge clk);
      io_bus_enable  = 1'b1;
      io_rw          = rw;
      io_address     = addr;
      io_write_data  = wdata;
      io_byte_enable = be;
      n = 0; got = 0; rdata = '0; extra = 0;
      while (!got && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (io_acknowledge) begin
            got   = 1;
            rdata = io_read_data;
         end
      end
      lat = got ? n : -1;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         if (io_acknowledge) extra++;
      end
      @(negedge clk);
      io_bus_enable = 1'b0;
      @(posedge clk); #1;
      if (io_acknowledge) extra++;
   endtask

   task automatic rd(input string tag, input logic [15:0] addr, input logic [15:0] exp);
      logic [15:0] d;
      int lat, extra;
      xfer(1'b1, addr, 16'h0000, 2'b00, 0, d, lat, extra);
      chk({tag, " data"}, {16'h0, d}, {16'h0, exp});
      chk({tag, " lat"}, lat, 2);
   endtask

   task automatic wr(input string tag, input logic [15:0] addr, input logic [15:0] data,
                     input logic [1:0] be);
      logic [15:0] d;
      int lat, extra;
      xfer(1'b0, addr, data, be, 0, d, lat, extra);
      chk({tag, " lat"}, lat, 2);
   endtask

   initial begin
      logic [15:0] d;
      int lat, extra, n;

      reset = 1'b1; io_address = '0; io_bus_enable = 1'b0; io_byte_enable = '0;
      io_rw = 1'b0; io_write_data = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst ack", {31'h0, io_acknowledge}, 0);
      chk("rst rdata", {16'h0, io_read_data}, 0);
      chk("rst irq", {31'h0, io_irq}, 0);
      @(negedge clk);
      reset = 1'b0;

      // ID read, request held three extra cycles.
      xfer(1'b1, 16'h0000, 16'h0000, 2'b00, 3, d, lat, extra);
      chk("id data", {16'h0, d}, 32'h5A17);
      chk("id lat", lat, 2);
      chk("id extra acks", extra, 0);
      rd("scratch rst", 16'h0002, 16'h0000);

      // Byte lanes.
      wr("scr lo", 16'h0002, 16'hBEEF, 2'b01);
      rd("scr lo rd", 16'h0002, 16'h00EF);
      wr("scr hi", 16'h0002, 16'h12FF, 2'b10);
      rd("scr hi rd", 16'h0002, 16'h12EF);
      wr("scr be0", 16'h0002, 16'h0000, 2'b00);
      rd("scr be0 rd", 16'h0002, 16'h12EF);
      rd("scr odd addr", 16'h0003, 16'h12EF);
      wr("id wr", 16'h0000, 16'hFFFF, 2'b11);
      rd("id ro", 16'h0000, 16'h5A17);

      // Unmapped offsets.
      wr("unmapped wr", 16'h0020, 16'hFFFF, 2'b11);
      rd("unmapped rd", 16'h0020, 16'h0000);
`ifndef IO_BUS_TIMER_PRESCALE_EN
      wr("0c wr", 16'h000C, 16'h00FF, 2'b11);
      rd("0c rd", 16'h000C, 16'h0000);
`endif

      // One-shot: LOAD=3, CTRL=irq_en|enable.
      wr("load3", 16'h0004, 16'h0003, 2'b11);
      wr("ctrl5", 16'h0006, 16'h0005, 2'b01);
      chk("os count0", {16'h0, dut.count_q}, 3);
      @(posedge clk); #1; chk("os count1", {16'h0, dut.count_q}, 2);
      @(posedge clk); #1; chk("os count2", {16'h0, dut.count_q}, 1);
      @(posedge clk); #1; chk("os count3", {16'h0, dut.count_q}, 0);
      chk("os not expired", {31'h0, dut.expired_q}, 0);
      @(posedge clk); #1;
      chk("os expired", {31'h0, dut.expired_q}, 1);
      chk("os irq lag", {31'h0, io_irq}, 0);
      @(posedge clk); #1;
      chk("os irq", {31'h0, io_irq}, 1);
      rd("os ctrl", 16'h0006, 16'h0004);
      rd("os count hold", 16'h0008, 16'h0000);
      rd("os status", 16'h000A, 16'h0001);
      rd("os status again", 16'h000A, 16'h0001);
      chk("os irq held", {31'h0, io_irq}, 1);

      wr("w1c", 16'h000A, 16'h0001, 2'b01);
      chk("w1c expired", {31'h0, dut.expired_q}, 0);
      chk("w1c irq lag", {31'h0, io_irq}, 1);
      @(posedge clk); #1;
      chk("w1c irq", {31'h0, io_irq}, 0);

      // Autoreload, period 3 edges; W1C race on an expiry edge, then on a quiet edge.
      wr("load2", 16'h0004, 16'h0002, 2'b11);
      wr("ctrl7", 16'h0006, 16'h0007, 2'b01);
      chk("ar count", {16'h0, dut.count_q}, 2);
      repeat (2) @(posedge clk);
      wr("ar w1c race", 16'h000A, 16'h0001, 2'b01);
      chk("ar race expired", {31'h0, dut.expired_q}, 1);
      chk("ar race reload", {16'h0, dut.count_q}, 2);
      chk("ar race irq", {31'h0, io_irq}, 1);
      wr("ar w1c quiet", 16'h000A, 16'h0001, 2'b01);
      chk("ar quiet expired", {31'h0, dut.expired_q}, 0);
      chk("ar quiet irq lag", {31'h0, io_irq}, 1);
      @(posedge clk); #1;
      chk("ar quiet irq", {31'h0, io_irq}, 0);
      wr("ar stop", 16'h0006, 16'h0000, 2'b01);
      wr("ar clr", 16'h000A, 16'h0001, 2'b01);
      rd("ar status", 16'h000A, 16'h0000);

`ifdef IO_BUS_TIMER_PRESCALE_EN
      wr("ps set", 16'h000C, 16'h0003, 2'b01);
      rd("ps rd", 16'h000C, 16'h0003);
      wr("ps load", 16'h0004, 16'h0002, 2'b11);
      wr("ps en", 16'h0006, 16'h0001, 2'b01);
      repeat (11) @(posedge clk);
      #1;
      chk("ps 11 cycles", {31'h0, dut.expired_q}, 0);
      @(posedge clk); #1;
      chk("ps 12 cycles", {31'h0, dut.expired_q}, 1);
`endif

      // Put state in every register, then reset during WAIT.
      wr("pre rst load", 16'h0004, 16'h0002, 2'b11);
      wr("pre rst ctrl", 16'h0006, 16'h0005, 2'b01);
      repeat (6) @(posedge clk);
      #1;
      chk("pre rst irq", {31'h0, io_irq}, 1);
      @(negedge clk);
      io_bus_enable = 1'b1; io_rw = 1'b1; io_address = 16'h0000; io_byte_enable = 2'b00;
      @(posedge clk); #1;
      chk("wait ack", {31'h0, io_acknowledge}, 0);
      @(negedge clk);
      reset = 1'b1;
      @(posedge clk); #1;
      chk("mid rst ack", {31'h0, io_acknowledge}, 0);
      chk("mid rst rdata", {16'h0, io_read_data}, 0);
      chk("mid rst irq", {31'h0, io_irq}, 0);
      @(negedge clk);
      reset = 1'b0;
      n = 0; lat = -1;
      while (lat < 0 && n < 40) begin
         @(posedge clk); #1;
         n++;
         if (io_acknowledge) begin
            lat = n;
            d   = io_read_data;
         end
      end
      chk("fresh lat", lat, 2);
      chk("fresh data", {16'h0, d}, 32'h5A17);
      @(negedge clk);
      io_bus_enable = 1'b0;
      repeat (2) @(posedge clk);
      rd("post rst scratch", 16'h0002, 16'h0000);
      rd("post rst load", 16'h0004, 16'h0000);
      rd("post rst ctrl", 16'h0006, 16'h0000);
      rd("post rst count", 16'h0008, 16'h0000);
      rd("post rst status", 16'h000A, 16'h0000);
      chk("post rst irq", {31'h0, io_irq}, 0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
